rx_frame_sampler: RTL and testbench

RX_FRAME_SAMPLER -- requirements
Module: rx_frame_sampler

---
 rtl/rx_frame_sampler.sv | 170 +++++++++++++++++
 tb/tb_rx_frame_sampler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rx_frame_sampler.sv
// Oversampled asynchronous serial receiver: synchroniser, 3-tap majority vote,
// start/data/parity/stop framing with parity, framing and break detection.
module rx_frame_sampler #(
    parameter int OVS         = 16,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 baud_clk,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 false_start,
    output logic                 busy
);
    localparam int CW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic [1:0]             hist;
    logic [2:0]             win;
    logic                   rs, primed, vote;
    logic [CW-1:0]          os_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   armed, p_en, p_odd, t_stop;
    logic                   perr_acc, ferr_acc, all_zero;
    logic                   sample, bit_end, detect, stop_last;

    // fill_q tracks how many real rxd samples have reached rs since reset, so the
    // reset value of the synchroniser can never arm the receiver on its own.
    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            fill_q <= '0;
            hist   <= 2'b11;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            hist   <= {hist[0], rs};
        end
    end

    assign rs     = sync_q[SYNC_STAGES-1];
    assign primed = fill_q[SYNC_STAGES-1];
    // Vote window: rs at the sample tick plus the two ticks before it.
    assign win    = {hist, rs};
    assign vote   = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);

    assign sample    = (os_cnt == CW'(OVS/2));
    assign bit_end   = (os_cnt == CW'(OVS-1));
    assign detect    = (state == IDLE) && armed && !rs;
    assign stop_last = (state == STOP) && sample && (bit_cnt == BW'(t_stop));

    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            os_cnt      <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            armed       <= 1'b0;
            p_en        <= 1'b0;
            p_odd       <= 1'b0;
            t_stop      <= 1'b0;
            perr_acc    <= 1'b0;
            ferr_acc    <= 1'b0;
            all_zero    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            false_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            false_start <= 1'b0;
            if (state != IDLE)
                os_cnt <= bit_end ? '0 : os_cnt + 1'b1;
            case (state)
                IDLE: begin
                    os_cnt  <= '0;
                    bit_cnt <= '0;
                    if (rs && primed)
                        armed <= 1'b1;
                    if (detect) begin
                        state    <= START;
                        os_cnt   <= CW'(1);
                        busy     <= 1'b1;
                        p_en     <= parity_en;
                        p_odd    <= parity_odd;
                        t_stop   <= two_stop;
                        perr_acc <= 1'b0;
                        ferr_acc <= 1'b0;
                        all_zero <= 1'b1;
                    end
                end
                START: begin
                    if (sample && vote) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        false_start <= 1'b1;
                    end else if (bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
                        if (vote)
                            all_zero <= 1'b0;
                    end
                    if (bit_end) begin
                        if (bit_cnt == BW'(DATA_BITS-1)) begin
                            bit_cnt <= '0;
                            state   <= p_en ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (sample) begin
                        perr_acc <= ((^shreg) ^ vote) != p_odd;
                        if (vote)
                            all_zero <= 1'b0;
                    end
                    if (bit_end)
                        state <= STOP;
                end
                STOP: begin
                    if (stop_last) begin
                        // Leave mid-bit so a back-to-back start edge is not missed.
                        state      <= IDLE;
                        os_cnt     <= '0;
                        bit_cnt    <= '0;
                        busy       <= 1'b0;
                        rx_valid   <= 1'b1;
                        rx_data    <= shreg;
                        parity_err <= perr_acc;
                        frame_err  <= ferr_acc | !vote;
                        break_det  <= all_zero & !vote;
                        if (all_zero && !vote)
                            armed <= 1'b0;
                    end else begin
                        if (sample) begin
                            if (!vote)
                                ferr_acc <= 1'b1;
                            else
                                all_zero <= 1'b0;
                        end
                        if (bit_end)
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_frame_sampler.sv
// Directed bench for rx_frame_sampler: stimulus pushes expected frames into a
// queue, an independent monitor pops and compares on every rx_valid.
module tb_rx_frame_sampler;
    localparam int OVS = 16;
    localparam int DB  = 8;

    logic          baud_clk = 1'b0;
    logic          reset, rxd, parity_en, parity_odd, two_stop;
    logic [DB-1:0] rx_data;
    logic          rx_valid, parity_err, frame_err, break_det, false_start, busy;

    rx_frame_sampler #(.OVS(OVS), .DATA_BITS(DB), .SYNC_STAGES(2)) dut (
        .baud_clk(baud_clk), .reset(reset), .rxd(rxd),
        .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
        .frame_err(frame_err), .break_det(break_det),
        .false_start(false_start), .busy(busy)
    );

    always #5 baud_clk = ~baud_clk;

    typedef struct {
        logic [7:0] data;
        logic       perr, ferr, brk;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0, bad = 0;
    int   cyc = 0, start_cyc = 0;
    int   fs_seen = 0, fs_exp = 0, vld_seen = 0;

    always @(posedge baud_clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    always @(negedge baud_clk) begin
        if (!reset) begin
            if (false_start) fs_seen++;
            if (rx_valid) begin
                vld_seen++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rx_valid: got data %0h want no frame", rx_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rx_data", rx_data, e.data);
                    check("parity_err", parity_err, e.perr);
                    check("frame_err", frame_err, e.ferr);
                    check("break_det", break_det, e.brk);
                    check("busy_at_valid", busy, 0);
                    if (e.lat >= 0) check("latency", cyc - start_cyc, e.lat);
                end
            end
        end
    end

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge baud_clk);
    endtask

    task automatic hold_bit(input logic b);
        rxd = b;
        repeat (OVS) @(negedge baud_clk);
    endtask

    // flip: toggle all mode inputs right after the start bit; the frame must not change.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic po,
                              input logic ts, input logic pbit, input logic s2bit,
                              input bit flip, input exp_t e);
        parity_en = pe; parity_odd = po; two_stop = ts;
        sb.push_back(e);
        @(negedge baud_clk);
        start_cyc = cyc;
        hold_bit(1'b0);
        if (flip) begin
            parity_en = ~pe; parity_odd = ~po; two_stop = ~ts;
        end
        for (int i = 0; i < DB; i++) hold_bit(d[i]);
        if (pe) hold_bit(pbit);
        hold_bit(1'b1);
        if (ts) hold_bit(s2bit);
        parity_en = pe; parity_odd = po; two_stop = ts;
        idle(32);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] partial;
        reset = 1'b1; rxd = 1'b1;
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        #23;
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_flags", {parity_err, frame_err, break_det}, 0);
        check("rst_false_start", false_start, 0);
        check("rst_busy", busy, 0);
        @(negedge baud_clk);
        reset = 1'b0;
        idle(20);

        // 8N1 0xA5; last stop sampled 16*9+8 ticks after detection, +2 sync, +1 output.
        send_frame(8'hA5, 0, 0, 0, 0, 1, 0, '{8'hA5, 0, 0, 0, 155});
        // 8E1 0x03: two ones, parity bit 1 -> error; parity bit 0 -> clean.
        send_frame(8'h03, 1, 0, 0, 1, 1, 0, '{8'h03, 1, 0, 0, -1});
        send_frame(8'h03, 1, 0, 0, 0, 1, 0, '{8'h03, 0, 0, 0, -1});
        // 8O1 0x03 with parity bit 1 -> odd count of ones, clean.
        send_frame(8'h03, 1, 1, 0, 1, 1, 0, '{8'h03, 0, 0, 0, -1});

        // 4-tick glitch: vote at mid start bit is high.
        rxd = 1'b0;
        repeat (4) @(negedge baud_clk);
        fs_exp++;
        idle(40);
        check("glitch_false_start", fs_seen, fs_exp);
        check("glitch_rx_data_held", rx_data, 8'h03);

        // 8N2 0x5A, second stop 0. The receiver returns to IDLE mid-bit with the
        // line still low, re-detects a start and rejects it as a false start.
        send_frame(8'h5A, 0, 0, 1, 0, 0, 0, '{8'h5A, 0, 1, 0, -1});
        fs_exp++;
        check("stop2_false_start", fs_seen, fs_exp);

        // Break: line low for three frame times, then high.
        parity_en = 1'b0; two_stop = 1'b0;
        sb.push_back('{8'h00, 0, 1, 1, -1});
        @(negedge baud_clk);
        rxd = 1'b0;
        repeat (3 * 10 * OVS) @(negedge baud_clk);
        check("break_busy_idle", busy, 0);
        check("break_flag_held", break_det, 1);
        idle(64);
        send_frame(8'h11, 0, 0, 0, 0, 1, 1, '{8'h11, 0, 0, 0, -1});

        // Reset in the middle of data bit 4, line then held low: no frame may start.
        partial = 8'h3C;
        @(negedge baud_clk);
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(partial[i]);
        rxd = partial[4];
        repeat (8) @(negedge baud_clk);
        check("busy_before_reset", busy, 1);
        #3 reset = 1'b1;
        #1;
        check("midrst_rx_data", rx_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_flags", {rx_valid, parity_err, frame_err, break_det, false_start}, 0);
        rxd = 1'b0;
        repeat (4) @(negedge baud_clk);
        reset = 1'b0;
        repeat (100) @(negedge baud_clk);
        check("low_after_reset_busy", busy, 0);
        idle(32);
        send_frame(8'hC3, 0, 0, 0, 0, 1, 0, '{8'hC3, 0, 0, 0, -1});

        idle(40);
        check("queue_empty", sb.size(), 0);
        check("false_start_count", fs_seen, fs_exp);
        check("rx_valid_count", vld_seen, 8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
